gauss_filter_rt: RTL
====================

// Module: gauss_filter_rt
// PURPOSE
//  Runtime-configurable Gaussian (binomial) smoothing filter with valid/ready flow control.
//  Takes a full WINDOW_SIZE x WINDOW_SIZE pixel window per beat and outputs one filtered pixel.
//  Kernel size is selected per sample (3x3 / 5x5 / 7x7 / bypass). Output normalisation is rounded.
//  Sits after the line-buffer/window generator and before the downstream pixel consumer.
//  Next generation of the fixed-kernel gauss_filter.
// PARAMETERS
//  PIX_DATA_W    12               pixel width, unsigned
//  WINDOW_SIZE   7                max window; legal values 3, 5, 7
//  INPUTS_AMOUNT WINDOW_SIZE**2   taps per beat, row-major, index 0 = top-left
//  ROUND_EN      1                1: round-half-up before shift; 0: truncate
// PORTS
//  clk_i         in   1                           clock
//  rst_i         in   1                           async reset, active-high
//  kernel_sel_i  in   2                           0=3x3, 1=5x5, 2=7x7, 3=bypass (centre pixel)
//  data_valid_i  in   1                           input beat valid
//  data_ready_o  out  1                           block can accept a beat
//  data_i        in   INPUTS_AMOUNT*PIX_DATA_W    pixel window
//  data_valid_o  out  1                           output pixel valid
//  data_ready_i  in   1                           downstream accepts output
//  data_o        out  PIX_DATA_W                  filtered pixel
// BEHAVIOUR
//  - One clock (clk_i). Reset is asynchronous and active-high (rst_i).
//  - Reset: data_valid_o=0, data_o=0, all stage valids=0, all in-flight beats discarded.
//    data_ready_o=0 while rst_i=1.
//  - Handshakes: input transfer when data_valid_i & data_ready_o. Output transfer when
//    data_valid_o & data_ready_i. data_valid_o and data_o hold stable until transferred.
//  - Pipeline: 1 multiply stage, CLOG2(INPUTS_AMOUNT) registered adder-tree levels, 1 normalise stage.
//    Latency L = CLOG2(INPUTS_AMOUNT)+2 clocks: 8 for 7x7 max, 6 for 3x3 max.
//  - Flow control: global enable en = !data_valid_o | data_ready_i; data_ready_o = en (when not in reset).
//    All stages (data and valid) advance only when en=1. Bubbles propagate as valid=0.
//    Full rate: one beat per clock when data_ready_i is held high.
//  - Mode: kernel_sel_i is captured with each accepted beat and travels with it as a per-stage tag.
//    Mode changes between consecutive beats take effect on exactly that beat; no flush is needed.
//  - sel above WINDOW_SIZE clamps to the largest legal kernel (e.g. WINDOW_SIZE=5, sel=2 -> 5x5).
//  - Kernels: binomial 1-2-1 (3x3, sum 16, shift 4), 1-4-6-4-1 (5x5, sum 256, shift 8),
//    1-6-15-20-15-6-1 (7x7, sum 4096, shift 12). Each kernel is centred in the window;
//    taps outside the kernel get coefficient 0. Bypass uses centre weight 1 and shift 0.
//  - Widths: product = PIX_DATA_W+9 bits (max coefficient 400). Sum = product width + CLOG2(INPUTS_AMOUNT) bits.
//  - Normalise: out = (sum + (ROUND_EN ? 2^(shift-1) : 0)) >> shift; bypass adds no rounding term.
//    Result is saturated to 2^PIX_DATA_W-1. Saturation cannot trigger for the legal kernels; it is a safety clamp.
//  - Simultaneous output transfer and new input in the same clock: both occur, no beat lost or duplicated.
//  - Reset asserted mid-stream: outputs clear immediately. The first beat accepted after reset is the
//    first beat to emerge.
// TESTING
//  - Flat window, all taps 1000, each sel 0..3, ready=1 -> data_o=1000, first valid L clocks after accept.
//  - Impulse 4095 at centre only: sel=2 -> 400, sel=0 -> 1024; with ROUND_EN=0, sel=0 -> 1023.
//  - Stream of 20 beats with sel cycling 0,1,2,3 per beat -> each output matches its own sel model, in order.
//  - data_ready_i low for 5 clocks mid-stream -> data_o/data_valid_o held, data_ready_o=0, no loss/dup.
//  - Random valid/ready at 50% each, 1000 beats -> output sequence equals reference model, nothing dropped.
//  - rst_i pulsed with 4 beats in flight -> data_valid_o=0 at once; post-reset beats emerge intact after L.

Source files
------------

// File: rtl/gauss_filter_rt.sv
// Runtime-selectable binomial smoothing filter (3x3/5x5/7x7/bypass).
// Multiply stage, registered adder tree, rounding normaliser, valid/ready flow.
module gauss_filter_rt #(
  parameter int PIX_DATA_W    = 12,
  parameter int WINDOW_SIZE   = 7,
  parameter int INPUTS_AMOUNT = WINDOW_SIZE**2,
  parameter bit ROUND_EN      = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [1:0]                          kernel_sel_i,
  input  logic                                data_valid_i,
  output logic                                data_ready_o,
  input  logic [INPUTS_AMOUNT*PIX_DATA_W-1:0] data_i,
  output logic                                data_valid_o,
  input  logic                                data_ready_i,
  output logic [PIX_DATA_W-1:0]               data_o
);

  localparam int LEVELS = $clog2(INPUTS_AMOUNT);
  localparam int PADDED = 1 << LEVELS;
  localparam int HALF   = PADDED / 2;
  localparam int PROD_W = PIX_DATA_W + 9;
  localparam int SUM_W  = PROD_W + LEVELS;
  localparam int CENTRE = INPUTS_AMOUNT / 2;

  localparam logic [1:0] BYPASS  = 2'd3;
  localparam logic [1:0] MAX_SEL = 2'((WINDOW_SIZE - 3) / 2);

  function automatic int binom(input int n, input int i);
    int v;
    v = 1;
    for (int j = 0; j < i; j++) v = v * (n - j) / (j + 1);
    return v;
  endfunction

  // Kernel of size 2*m+3 centred in the window; taps outside it weigh 0.
  function automatic int coef(input int m, input int idx);
    int k, o, r, c;
    r = idx / WINDOW_SIZE;
    c = idx % WINDOW_SIZE;
    if (m == 3) return (idx == CENTRE) ? 1 : 0;
    k = 2 * m + 3;
    o = (WINDOW_SIZE - k) / 2;
    if (r < o || r >= o + k || c < o || c >= o + k) return 0;
    return binom(k - 1, r - o) * binom(k - 1, c - o);
  endfunction

  function automatic logic [8:0] coef_of(
    input logic [1:0] m,
    input int         idx
  );
    logic [8:0] cf;
    cf = '0;
    case (m)
      2'd0:    cf = 9'(coef(0, idx));
      2'd1:    cf = 9'(coef(1, idx));
      2'd2:    cf = 9'(coef(2, idx));
      default: cf = 9'(coef(3, idx));
    endcase
    return cf;
  endfunction

  logic              en;
  logic              accept;
  logic [1:0]        mode_d;
  logic [PROD_W-1:0] prod_d [INPUTS_AMOUNT];

  logic              vld_q  [LEVELS+1];
  logic [1:0]        tag_q  [LEVELS+1];
  logic [PROD_W-1:0] prod_q [PADDED];
  logic [SUM_W-1:0]  sum_q  [LEVELS][HALF];

  logic [SUM_W-1:0]  sum_fin;
  logic [3:0]        sh;
  logic [SUM_W:0]    rnd;
  logic [SUM_W:0]    rounded;
  logic [SUM_W:0]    shifted;
  logic [PIX_DATA_W-1:0] norm;

  assign en           = !data_valid_o || data_ready_i;
  assign data_ready_o = en && !rst_i;
  assign accept       = data_valid_i && data_ready_o;

  always_comb begin
    mode_d = kernel_sel_i;
    unique case (1'b1)
      (kernel_sel_i == BYPASS):
        mode_d = BYPASS;
      (kernel_sel_i != BYPASS && kernel_sel_i > MAX_SEL):
        mode_d = MAX_SEL;
      default:
        mode_d = kernel_sel_i;
    endcase
  end

  always_comb begin
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      prod_d[i] = PROD_W'(data_i[i*PIX_DATA_W +: PIX_DATA_W])
                * PROD_W'(coef_of(mode_d, i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n <= LEVELS; n++) begin
        vld_q[n] <= 1'b0;
        tag_q[n] <= '0;
      end
      for (int i = 0; i < PADDED; i++) prod_q[i] <= '0;
      for (int n = 0; n < LEVELS; n++) begin
        for (int j = 0; j < HALF; j++) sum_q[n][j] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= accept;
      tag_q[0] <= mode_d;
      for (int i = 0; i < PADDED; i++) prod_q[i] <= '0;
      for (int i = 0; i < INPUTS_AMOUNT; i++) prod_q[i] <= prod_d[i];
      for (int n = 1; n <= LEVELS; n++) begin
        vld_q[n] <= vld_q[n-1];
        tag_q[n] <= tag_q[n-1];
      end
      for (int j = 0; j < HALF; j++) begin
        sum_q[0][j] <= SUM_W'(prod_q[2*j]) + SUM_W'(prod_q[2*j+1]);
      end
      for (int n = 1; n < LEVELS; n++) begin
        for (int j = 0; j < (HALF >> n); j++) begin
          sum_q[n][j] <= sum_q[n-1][2*j] + sum_q[n-1][2*j+1];
        end
      end
    end
  end

  assign sum_fin = sum_q[LEVELS-1][0];

  always_comb begin
    case (tag_q[LEVELS])
      2'd0:    sh = 4'd4;
      2'd1:    sh = 4'd8;
      2'd2:    sh = 4'd12;
      default: sh = 4'd0;
    endcase
    rnd = '0;
    if (ROUND_EN && sh != 4'd0) rnd = (SUM_W+1)'(1) << (sh - 4'd1);
    rounded = {1'b0, sum_fin} + rnd;
    shifted = rounded >> sh;
    // Unreachable with binomial weights; kept as a safety clamp.
    if (|shifted[SUM_W:PIX_DATA_W]) norm = '1;
    else norm = shifted[PIX_DATA_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else if (en) begin
      data_valid_o <= vld_q[LEVELS];
      if (vld_q[LEVELS]) data_o <= norm;
    end
  end

endmodule
